cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the CDB write-back ports among the result FIFOs of all execution IQs (ALU, MDU, LSU).
- Each cycle it grants up to CDB_COUNT requesters in round-robin order, with a starvation override, and registers the granted cdb_info_t onto the CDB.
- Sits between the per-IQ execute FIFOs and the ROB/CDB broadcast.

Parameters:
REQ_COUNT, 4, number of requesting result FIFOs
CDB_COUNT, 2, number of CDB broadcast ports
STARVE_LIMIT, 7, cycles a valid requester may wait before forced priority (counter width $clog2(STARVE_LIMIT+1))

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
flush  input  1  pipeline flush, synchronous, same effect as rst
req_valid_i  input  [REQ_COUNT]  requester has a result
req_data_i  input  cdb_info_t[REQ_COUNT]  requester payload
req_ready_o  output  [REQ_COUNT]  requester granted and popped this cycle
cdb_ready_i  input  1  ROB accepts all current CDB slots this cycle
cdb_valid_o  output  [CDB_COUNT]  CDB slot valid (registered)
cdb_data_o  output  cdb_info_t[CDB_COUNT]  CDB slot payload (registered)

Behaviour:
- Reset/flush: cdb_valid_o=0, cdb_data_o=0, rr_q=0, all wait counters=0. req_ready_o is 0 during a reset/flush cycle.
- Output stage: load = (cdb_valid_o==0) | cdb_ready_i. The whole slot vector advances together, with no partial acceptance.
- Grant is combinational when load=1:
  - Scan requesters in order rr_q, rr_q+1, … mod REQ_COUNT.
  - The first CDB_COUNT with req_valid_i are granted.
  - The k-th granted requester goes to slot k. Unused slots get valid=0 and data=0.
- Starvation override: any requester with wait_q==STARVE_LIMIT and valid is granted first, into slot 0 upward, in ascending index order. Remaining slots continue with the round-robin scan, skipping already-granted requesters.
- req_ready_o[i] = load & grant[i]. The requester pops on req_valid_i & req_ready_o.
- Latency: granted payload appears on cdb_*_o on the next clock edge. It holds stable while cdb_ready_i=0.
- load=0: no grants, req_ready_o=0, and outputs hold.
- rr_q update:
  - On load with at least one round-robin grant: rr_q <= (index of last round-robin-granted requester + 1) mod REQ_COUNT.
  - If only starved requesters were granted, or nothing was granted: rr_q holds.
- Wait counters, per requester:
  - 0 when not valid or when granted.
  - Otherwise increment, saturating at STARVE_LIMIT.
  - Counters still increment during load=0.
- More than CDB_COUNT starved requesters: lowest indices win; the others stay saturated until granted.
- Flush in the same cycle as cdb_ready_i: flush wins. Outputs clear, and no grant occurs that cycle.
- req_valid_i deasserting without a grant is legal; the counter clears.
- Payload is never modified; the arbiter is transparent on data.

Optional Feature:
- Macro CDB_ARB_PERF_EN.
- When defined, add outputs perf_grant_cnt_o [32] and perf_stall_cnt_o [32]:
  - perf_grant_cnt_o counts popped requests (popcount of req_ready_o & req_valid_i).
  - perf_stall_cnt_o counts cycles with cdb_valid_o!=0 and cdb_ready_i=0.
  - Both reset to 0 on rst only (not flush) and wrap at 2^32.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Defaults, cdb_ready_i=1, req_valid_i=4'b1111 for 3 cycles:
  - Cycle grants are {0,1}, then {2,3}, then {0,1}.
  - cdb_data_o matches each requester's payload one cycle later.
  - rr_q sequence is 0→2→0→2.
- req_valid_i=4'b0100 only, rr_q=0: slot0=req2, slot1 valid=0; rr_q becomes 3.
- cdb_ready_i=0 for 5 cycles with outputs valid:
  - cdb_*_o held constant and req_ready_o=0.
  - Wait counters of pending valid requesters reach 5.
  - When ready returns, grants resume from the unchanged rr_q.
- STARVE_LIMIT=2, req3 valid throughout, cdb_ready_i=0 for 3 cycles, then 1:
  - On the cycle ready returns, req3 is granted into slot 0 ahead of the round-robin order.
  - rr_q is updated only by the round-robin grant in slot 1.
- Flush while cdb_valid_o=2'b11 and cdb_ready_i=1:
  - Next cycle cdb_valid_o=0, rr_q=0, counters=0, and no req_ready_o during the flush cycle.
- CDB_ARB_PERF_EN defined, 10 cycles of full 4-req traffic with ready=1, then 4 stall cycles:
  - perf_grant_cnt_o=20 and perf_stall_cnt_o=4.
  - A subsequent flush leaves both counters unchanged.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB write-back arbiter: round-robin grant of up to CDB_COUNT result FIFOs per cycle, with starvation override.
// Optional performance counters are enabled by defining CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int REQ_COUNT    = 4,
  parameter int CDB_COUNT    = 2,
  parameter int STARVE_LIMIT = 7,
  parameter int DATA_W       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [REQ_COUNT-1:0]              req_valid_i,
  input  logic [REQ_COUNT-1:0][DATA_W-1:0]  req_data_i,
  output logic [REQ_COUNT-1:0]              req_ready_o,
  input  logic                              cdb_ready_i,
  output logic [CDB_COUNT-1:0]              cdb_valid_o,
  output logic [CDB_COUNT-1:0][DATA_W-1:0]  cdb_data_o
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_grant_cnt_o,
  output logic [31:0]                       perf_stall_cnt_o
`endif
);

  localparam int IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [IDX_W-1:0]                 rr_q;
  logic [IDX_W-1:0]                 rr_next;
  logic [REQ_COUNT-1:0][CNT_W-1:0]  wait_q;
  logic [REQ_COUNT-1:0]             starved;
  logic [REQ_COUNT-1:0]             grant;
  logic [CDB_COUNT-1:0]             slot_valid;
  logic [CDB_COUNT-1:0][DATA_W-1:0] slot_data;
  logic                             rr_hit;
  logic                             load;

  assign load = ~(|cdb_valid_o) | cdb_ready_i;

  always_comb begin
    for (int i = 0; i < REQ_COUNT; i++) begin
      starved[i] = req_valid_i[i] && (wait_q[i] == LIMIT);
    end
  end

  always_comb begin
    int               slot_cnt;
    int               sum;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_rr;
    grant      = '0;
    slot_valid = '0;
    slot_data  = '0;
    rr_hit     = 1'b0;
    slot_cnt   = 0;
    sum        = 0;
    idx        = '0;
    last_rr    = rr_q;
    rr_next    = rr_q;
    // starved requesters take the lowest slots in ascending index order
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (starved[i] && slot_cnt < CDB_COUNT) begin
        grant[i] = 1'b1;
        for (int s = 0; s < CDB_COUNT; s++) begin
          if (s == slot_cnt) begin
            slot_valid[s] = 1'b1;
            slot_data[s]  = req_data_i[i];
          end
        end
        slot_cnt = slot_cnt + 1;
      end
    end
    for (int k = 0; k < REQ_COUNT; k++) begin
      sum = int'(rr_q) + k;
      if (sum >= REQ_COUNT) sum = sum - REQ_COUNT;
      idx = IDX_W'(sum);
      if (req_valid_i[idx] && !grant[idx] && slot_cnt < CDB_COUNT) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < CDB_COUNT; s++) begin
          if (s == slot_cnt) begin
            slot_valid[s] = 1'b1;
            slot_data[s]  = req_data_i[idx];
          end
        end
        slot_cnt = slot_cnt + 1;
        last_rr  = idx;
        rr_hit   = 1'b1;
      end
    end
    sum = int'(last_rr) + 1;
    if (sum >= REQ_COUNT) sum = 0;
    rr_next = IDX_W'(sum);
  end

  assign req_ready_o = grant & {REQ_COUNT{load & ~rst & ~flush}};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_valid_o <= '0;
      cdb_data_o  <= '0;
      rr_q        <= '0;
      wait_q      <= '0;
    end else begin
      if (load) begin
        cdb_valid_o <= slot_valid;
        cdb_data_o  <= slot_data;
        if (rr_hit) rr_q <= rr_next;
      end
      // counters keep running while the CDB is stalled so starvation is still seen
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (!req_valid_i[i] || req_ready_o[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != LIMIT) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  // perf counters survive flush; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      perf_grant_cnt_o <= perf_grant_cnt_o + 32'($countones(req_ready_o & req_valid_i));
      if ((|cdb_valid_o) && !cdb_ready_i && !flush) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: default instance plus a STARVE_LIMIT=2 instance on shared stimulus.
module tb_cdb_arbiter;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [3:0]        req_valid;
  logic [3:0][31:0]  req_data;
  logic              cdb_ready;
  logic [3:0]        ready_a;
  logic [3:0]        ready_b;
  logic [1:0]        valid_a;
  logic [1:0]        valid_b;
  logic [1:0][31:0]  data_a;
  logic [1:0][31:0]  data_b;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]       pg_a, ps_a, pg_b, ps_b;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] d0, d1, d2, d3;

  cdb_arbiter dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(ready_a),
    .cdb_ready_i(cdb_ready), .cdb_valid_o(valid_a), .cdb_data_o(data_a)
`ifdef CDB_ARB_PERF_EN
    , .perf_grant_cnt_o(pg_a), .perf_stall_cnt_o(ps_a)
`endif
  );

  cdb_arbiter #(.STARVE_LIMIT(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(ready_b),
    .cdb_ready_i(cdb_ready), .cdb_valid_o(valid_b), .cdb_data_o(data_b)
`ifdef CDB_ARB_PERF_EN
    , .perf_grant_cnt_o(pg_b), .perf_stall_cnt_o(ps_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d0 = 32'hCAFE_0000;
    d1 = 32'hCAFE_0011;
    d2 = 32'hCAFE_0022;
    d3 = 32'hCAFE_0033;
    req_data  = {d3, d2, d1, d0};
    rst       = 1'b1;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    chk("rst_ready",   64'(ready_a), 64'h0);
    chk("rst_valid",   64'(valid_a), 64'h0);
    chk("rst_data",    64'(data_a),  64'h0);
    chk("rst_rr",      64'(dut_a.rr_q), 64'h0);

    // full traffic: {0,1}, {2,3}, {0,1}
    rst = 1'b0;
    #1;
    chk("rr1_ready", 64'(ready_a), 64'h3);
    step();
    chk("rr1_valid", 64'(valid_a), 64'h3);
    chk("rr1_data",  64'(data_a),  {d1, d0});
    chk("rr1_rr",    64'(dut_a.rr_q), 64'h2);
    chk("rr2_ready", 64'(ready_a), 64'hC);
    step();
    chk("rr2_data",  64'(data_a),  {d3, d2});
    chk("rr2_rr",    64'(dut_a.rr_q), 64'h0);
    chk("rr3_ready", 64'(ready_a), 64'h3);
    step();
    chk("rr3_data",  64'(data_a),  {d1, d0});
    chk("rr3_rr",    64'(dut_a.rr_q), 64'h2);
    step();
    chk("rr4_rr",    64'(dut_a.rr_q), 64'h0);

    // single requester 2 from rr_q=0
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(ready_a), 64'h4);
    step();
    chk("single_valid", 64'(valid_a), 64'h1);
    chk("single_data",  64'(data_a),  {32'h0, d2});
    chk("single_rr",    64'(dut_a.rr_q), 64'h3);

    // CDB stall for 5 cycles
    req_valid = 4'b1111;
    cdb_ready = 1'b0;
    #1;
    chk("stall_ready0", 64'(ready_a), 64'h0);
    repeat (5) step();
    chk("stall_valid", 64'(valid_a), 64'h1);
    chk("stall_data",  64'(data_a),  {32'h0, d2});
    chk("stall_wait",  64'(dut_a.wait_q), 64'({4{3'd5}}));
    chk("stall_rr",    64'(dut_a.rr_q), 64'h3);
    chk("stall_ready", 64'(ready_a), 64'h0);
    cdb_ready = 1'b1;
    #1;
    chk("resume_ready", 64'(ready_a), 64'h9);
    step();
    chk("resume_valid", 64'(valid_a), 64'h3);
    chk("resume_data",  64'(data_a),  {d0, d3});
    chk("resume_rr",    64'(dut_a.rr_q), 64'h1);

    // flush with both slots valid and ready high
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(ready_a), 64'h0);
    step();
    chk("flush_valid", 64'(valid_a), 64'h0);
    chk("flush_data",  64'(data_a),  64'h0);
    chk("flush_rr",    64'(dut_a.rr_q), 64'h0);
    chk("flush_wait",  64'(dut_a.wait_q), 64'h0);
    chk("flush_valid_b", 64'(valid_b), 64'h0);

    // starvation: req3 waits through a stall on the STARVE_LIMIT=2 instance
    flush     = 1'b0;
    req_valid = 4'b1011;
    cdb_ready = 1'b1;
    step();
    chk("stv_pre_data", 64'(data_b), {d1, d0});
    chk("stv_pre_rr",   64'(dut_b.rr_q), 64'h2);
    req_valid = 4'b1000;
    cdb_ready = 1'b0;
    repeat (3) step();
    chk("stv_wait_b", 64'(dut_b.wait_q[3]), 64'h2);
    chk("stv_wait_a", 64'(dut_a.wait_q[3]), 64'h4);
    req_valid = 4'b1110;
    cdb_ready = 1'b1;
    #1;
    chk("stv_ready_b", 64'(ready_b), 64'hC);
    step();
    chk("stv_valid_b", 64'(valid_b), 64'h3);
    chk("stv_data_b",  64'(data_b),  {d2, d3});
    chk("stv_rr_b",    64'(dut_b.rr_q), 64'h3);
    chk("stv_clr_b",   64'(dut_b.wait_q[3]), 64'h0);
    chk("nostv_data_a", 64'(data_a), {d3, d2});
    chk("nostv_rr_a",   64'(dut_a.rr_q), 64'h0);

`ifdef CDB_ARB_PERF_EN
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_valid = 4'b1111;
    cdb_ready = 1'b1;
    repeat (10) step();
    cdb_ready = 1'b0;
    repeat (4) step();
    chk("perf_grant", 64'(pg_a), 64'd20);
    chk("perf_stall", 64'(ps_a), 64'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_grant_flush", 64'(pg_a), 64'd20);
    chk("perf_stall_flush", 64'(ps_a), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
